// File: rtl/water_level_encoder.sv
// Float-probe front end: synchronise, debounce and thermometer-validate three
// probes, then present a registered 2-bit level code with valid/fault/changed.
module water_level_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_low,
  input  logic       sensor_mid,
  input  logic       sensor_high,
  output logic [1:0] level,
  output logic       level_valid,
  output logic       fault,
  output logic       changed
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [1:0]       fill;
  logic             armed;
  logic [2:0]       cand;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt;

  logic             commit;
  logic             fresh;
  logic             dec_ok;
  logic [1:0]       dec_lvl;
  logic             load;

  state_t state;
  state_t state_nxt;

  // fill tracks how far post-reset samples have reached the synchroniser,
  // so stale flop contents are never counted towards a debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      fill  <= '0;
    end else begin
      sync1 <= {sensor_high, sensor_mid, sensor_low};
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  assign commit = armed && (cnt == CNT_MAX);
  assign fresh  = commit && ((state == INIT) || (cand != stable));

  always_ff @(posedge clk) begin
    if (reset) begin
      armed  <= 1'b0;
      cand   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else if (fill[1]) begin
      armed <= 1'b1;
      if (commit) begin
        stable <= cand;
      end
      if (!armed || (sync2 != cand)) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_lvl = 2'b00;
    case (cand)
      3'b000:  dec_lvl = 2'b00;
      3'b001:  dec_lvl = 2'b01;
      3'b011:  dec_lvl = 2'b10;
      3'b111:  dec_lvl = 2'b11;
      default: dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (fresh) begin
      unique case (state)
        INIT, VALID, FAULT: begin
          if (dec_ok) begin
            state_nxt = VALID;
            load      = 1'b1;
          end else begin
            state_nxt = FAULT;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_comb begin
    level_valid = 1'b0;
    fault       = 1'b0;
    unique case (state)
      VALID:   level_valid = 1'b1;
      FAULT:   fault       = 1'b1;
      default: level_valid = 1'b0;
    endcase
  end

  // level holds through FAULT; changed only reflects real code transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= 2'b00;
      changed <= 1'b0;
    end else begin
      changed <= load && (dec_lvl != level);
      if (load) begin
        level <= dec_lvl;
      end
    end
  end

endmodule

// File: tb/tb_water_level_encoder.sv
// Directed bench for water_level_encoder with DEBOUNCE_CYCLES=4.
// Outputs are checked 1 time unit after numbered rising edges.
module tb_water_level_encoder;

  logic       clk;
  logic       reset;
  logic       sensor_low;
  logic       sensor_mid;
  logic       sensor_high;
  logic [1:0] level;
  logic       level_valid;
  logic       fault;
  logic       changed;

  int vectors;
  int errs;
  int cyc;

  water_level_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sensor_low(sensor_low),
    .sensor_mid(sensor_mid),
    .sensor_high(sensor_high),
    .level(level),
    .level_valid(level_valid),
    .fault(fault),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_to(input int tgt);
    while (cyc < tgt) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic drive(input logic [2:0] v);
    {sensor_high, sensor_mid, sensor_low} = v;
  endtask

  // expected packed as {level, level_valid, fault, changed}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {level, level_valid, fault, changed};
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout edge=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    errs    = 0;
    cyc     = 0;
    reset   = 1'b1;
    drive(3'b000);

    tick_to(1);
    chk("reset", 5'b00000);
    reset = 1'b0;

    tick_to(7);
    chk("init_wait", 5'b00000);
    tick_to(8);
    chk("init_valid00", 5'b00100);
    tick_to(9);
    chk("init_hold", 5'b00100);

    tick_to(19);
    drive(3'b011);
    tick_to(25);
    chk("mid_pre", 5'b00100);
    tick_to(26);
    chk("mid_commit", 5'b10101);
    tick_to(27);
    chk("mid_pulse_end", 5'b10100);

    tick_to(30);
    drive(3'b111);
    for (int e = 31; e <= 45; e++) begin
      tick_to(e);
      chk("glitch", 5'b10100);
      if (e == 33) drive(3'b011);
    end

    drive(3'b111);
    tick_to(51);
    chk("high_pre", 5'b10100);
    tick_to(52);
    chk("high_commit", 5'b11101);
    tick_to(55);
    chk("high_hold", 5'b11100);
    drive(3'b101);
    tick_to(61);
    chk("fault_pre", 5'b11100);
    tick_to(62);
    chk("fault_enter", 5'b11010);
    tick_to(65);
    drive(3'b001);
    tick_to(71);
    chk("fault_hold", 5'b11010);
    tick_to(72);
    chk("fault_exit", 5'b01101);
    tick_to(73);
    chk("low_hold", 5'b01100);

    tick_to(75);
    drive(3'b000);
    tick_to(82);
    chk("crit_commit", 5'b00101);
    tick_to(85);
    drive(3'b111);
    tick_to(90);
    chk("mid_debounce", 5'b00100);
    reset = 1'b1;
    tick_to(91);
    chk("reset_mid", 5'b00000);
    reset = 1'b0;
    tick_to(97);
    chk("rearm_wait", 5'b00000);
    tick_to(98);
    chk("rearm_commit", 5'b11101);

    tick_to(100);
    drive(3'b000);
    tick_to(106);
    chk("back_pre", 5'b11100);
    tick_to(107);
    chk("back_commit", 5'b00101);

    tick_to(110);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) drive(((i / 3) % 2 == 0) ? 3'b111 : 3'b000);
      tick_to(111 + i);
      chk("toggle", 5'b00100);
    end
    drive(3'b111);
    tick_to(156);
    chk("settle_pre", 5'b00100);
    tick_to(157);
    chk("settle_commit", 5'b11101);
    tick_to(158);
    chk("settle_hold", 5'b11100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/water_level_encoder.md
Name: water_level_encoder

Overview:
- Upstream stage of the water-level LED matrix decoder: turns three raw float-probe inputs into the 2-bit level code that decoder consumes.
- Synchronises and debounces the probes, then validates them as a thermometer code.
- Outputs a registered level code, a valid flag, a fault flag and a one-cycle change pulse.
- The level code drives the decoder's data input directly.
- Level code meanings: 00 critical, 01 low, 10 mid, 11 high.

Parameters:
- DEBOUNCE_CYCLES, 50000: number of consecutive identical synchronised samples required before a probe vector is accepted. Legal minimum is 2.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sensor_low  input  1  lowest probe, 1 = submerged. Asynchronous to clk.
- sensor_mid  input  1  middle probe, 1 = submerged. Asynchronous.
- sensor_high  input  1  top probe, 1 = submerged. Asynchronous.
- level  output  2  registered level code for the matrix decoder.
- level_valid  output  1  1 while level reflects a valid debounced probe vector.
- fault  output  1  1 while the debounced probe vector is not a thermometer code.
- changed  output  1  one-cycle pulse on any edge where level takes a new value.

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high. It is sampled only on the rising edge of clk and overrides all other activity.
- Reset values:
  - level = 00, level_valid = 0, fault = 0, changed = 0.
  - Synchronisers, candidate and stable vectors = 000; debounce counter = 0; FSM = INIT.
- Reset asserted mid-debounce or in any state: every register returns to its reset value on that edge. No partial commit.
- Synchroniser:
  - Two flops per probe. The vector is s = {sensor_high, sensor_mid, sensor_low} after the second flop.
- Debounce:
  - If s != candidate: candidate <= s, cnt <= 0.
  - Else if cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Else, a commit occurs: stable <= candidate and cnt holds at DEBOUNCE_CYCLES-1.
  - A commit repeats every cycle while the input is steady; outputs only change when the decoded result differs.
- Latency:
  - Case: the input settles before edge k (the first edge that samples it) and then stays steady.
  - Result: stable, level, fault and changed update on edge k+DEBOUNCE_CYCLES+2.
  - Any input pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no commit.
- Decode of the committed vector:
  - 000 -> 00.
  - 001 -> 01.
  - 011 -> 10.
  - 111 -> 11.
  - Any other pattern (010, 100, 101, 110) is invalid.
- FSM states:
  - INIT: level_valid = 0, fault = 0, level = 00.
    - On the first commit, go to VALID if the vector is valid and load level.
    - Go to FAULT if the vector is invalid; level stays 00.
  - VALID: level_valid = 1, fault = 0.
    - A commit with a valid vector loads level.
    - A commit with an invalid vector goes to FAULT.
  - FAULT: level_valid = 0, fault = 1, level holds its last value (not forced to 00).
    - A commit with a valid vector goes to VALID and loads level.
- changed:
  - Asserted for exactly one cycle on the edge after which level differs from its previous value.
  - INIT->VALID with decoded 00 produces no pulse.
  - Entering or leaving FAULT pulses only if level changes.
- Simultaneous events:
  - reset wins over a commit on the same edge.
  - An input change on the commit edge is ignored for that commit; the committed value is the old candidate, and cnt restarts on the following edge.
- Counter: saturates at DEBOUNCE_CYCLES-1 and never wraps.

Test Plan:
(All scenarios run with DEBOUNCE_CYCLES = 4, CNT_W = 3.)
1. Reset then steady 000 first sampled at edge 2 -> level = 00, level_valid rises at edge 8, changed stays 0, fault = 0.
2. From VALID 00, drive 011 first sampled at edge 20 -> level = 10 at edge 26, changed = 1 only on edge 26, level_valid stays 1.
3. From level 10, pulse sensor_high for 3 cycles -> no commit; level stays 10, changed never asserts.
4. From level 11, drive invalid 101 -> fault = 1 and level_valid = 0 six edges after sampling, level holds 11. Then drive 001 -> fault = 0, level = 01, changed pulses once.
5. Assert reset for 1 cycle while cnt = 2 during a 000->111 transition -> all outputs return to reset values next edge. The FSM re-enters INIT and requires a full new debounce.
6. Toggle the 111 vector every 3 cycles for 40 cycles, then hold 111 -> no commit during toggling; level = 11 exactly 6 edges after the final settle.
